// File: rtl/lsr_window_loader.sv
// Sample window assembler feeding the LSR4 least-squares stage.
// Shifts accepted samples into a DATA_SIZE-point window and holds start until LSR4 signals done.
module lsr_window_loader #(
   parameter int DATA_SIZE = 7,
   parameter int WIDTH     = 16,
   parameter int HOP       = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic signed [WIDTH-1:0]           s_data,
   input  logic                              flush,
   output logic [DATA_SIZE*WIDTH-1:0]        win_data,
   output logic                              win_start,
   input  logic                              lsr_done,
   output logic [15:0]                       win_count,
   output logic [$clog2(DATA_SIZE+1)-1:0]    fill_level
);

   localparam int FL_W = $clog2(DATA_SIZE + 1);
   localparam logic [FL_W-1:0] LAST_LVL = FL_W'(DATA_SIZE - 1);
   localparam logic [FL_W-1:0] KEEP_LVL = FL_W'(DATA_SIZE - HOP);

   if (DATA_SIZE < 2) begin : g_bad_size
      $error("lsr_window_loader: DATA_SIZE must be >= 2");
   end
   if (HOP < 1 || HOP > DATA_SIZE) begin : g_bad_hop
      $error("lsr_window_loader: HOP must be in 1..DATA_SIZE");
   end

   typedef enum logic {ST_FILL, ST_WAIT} state_t;

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] win_q [DATA_SIZE];
   logic [FL_W-1:0]         fill_q, fill_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    ready_q;
   logic                    start_q;
   logic                    accept;
   logic                    shift_en;
   logic                    clear_en;

   assign accept = s_valid & ready_q & (state_q == ST_FILL);

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      shift_en = 1'b0;
      clear_en = 1'b0;
      if (flush) begin
         state_d  = ST_FILL;
         fill_d   = '0;
         clear_en = 1'b1;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  shift_en = 1'b1;
                  fill_d   = fill_q + FL_W'(1);
                  if (fill_q == LAST_LVL) state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Retained samples already sit in the high slots, so only the level rewinds.
               if (lsr_done) begin
                  cnt_d   = cnt_q + 16'd1;
                  fill_d  = KEEP_LVL;
                  state_d = ST_FILL;
               end
            end
            default: state_d = ST_FILL;
         endcase
      end
   end

   // Handshake outputs are registered from the next state so they change one edge after the event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FILL;
         fill_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == ST_FILL);
         start_q <= (state_d == ST_WAIT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DATA_SIZE; k++) win_q[k] <= '0;
      end else if (clear_en) begin
         for (int k = 0; k < DATA_SIZE; k++) win_q[k] <= '0;
      end else if (shift_en) begin
         for (int k = 0; k < DATA_SIZE - 1; k++) win_q[k] <= win_q[k+1];
         win_q[DATA_SIZE-1] <= s_data;
      end
   end

   for (genvar k = 0; k < DATA_SIZE; k++) begin : g_flat
      assign win_data[k*WIDTH +: WIDTH] = win_q[k];
   end

   assign s_ready    = ready_q;
   assign win_start  = start_q;
   assign win_count  = cnt_q;
   assign fill_level = fill_q;

endmodule

// File: tb/tb_lsr_window_loader.sv
// Directed bench for lsr_window_loader: one HOP=1 and one HOP=7 instance,
// ending in a randomized backpressure run scored against a small window model.
module tb_lsr_window_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         v1 = 1'b0, fl1 = 1'b0, dn1 = 1'b0;
   logic [15:0]  d1 = '0;
   logic         rdy1, st1;
   logic [111:0] wd1;
   logic [15:0]  cnt1;
   logic [2:0]   lvl1;

   logic         v7 = 1'b0, fl7 = 1'b0, dn7 = 1'b0;
   logic [15:0]  d7 = '0;
   logic         rdy7, st7;
   logic [111:0] wd7;
   logic [15:0]  cnt7;
   logic [2:0]   lvl7;

   int n_chk  = 0;
   int n_fail = 0;

   lsr_window_loader #(.DATA_SIZE(7), .WIDTH(16), .HOP(1)) u_h1 (
      .clk(clk), .rst(rst_n), .s_valid(v1), .s_ready(rdy1), .s_data(d1),
      .flush(fl1), .win_data(wd1), .win_start(st1), .lsr_done(dn1),
      .win_count(cnt1), .fill_level(lvl1)
   );

   lsr_window_loader #(.DATA_SIZE(7), .WIDTH(16), .HOP(7)) u_h7 (
      .clk(clk), .rst(rst_n), .s_valid(v7), .s_ready(rdy7), .s_data(d7),
      .flush(fl7), .win_data(wd7), .win_start(st7), .lsr_done(dn7),
      .win_count(cnt7), .fill_level(lvl7)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic [15:0] v);
      int guard = 0;
      v1 = 1'b1;
      d1 = v;
      while (!rdy1 && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("push1_timeout", 0, 1);
      tick();
      v1 = 1'b0;
   endtask

   task automatic push7(input logic [15:0] v);
      int guard = 0;
      v7 = 1'b1;
      d7 = v;
      while (!rdy7 && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("push7_timeout", 0, 1);
      tick();
      v7 = 1'b0;
   endtask

   function automatic logic [111:0] pack(input logic [15:0] m [7]);
      logic [111:0] f;
      for (int k = 0; k < 7; k++) f[k*16 +: 16] = m[k];
      return f;
   endfunction

   logic [15:0]  mwin [7];
   logic [2:0]   mfill;
   logic [15:0]  mcnt;
   logic         mwait;
   logic         pre_v, pre_d;
   logic [15:0]  pre_data;
   logic [111:0] held;

   initial begin
      // Reset with s_valid asserted: nothing may be accepted.
      v1 = 1'b1; d1 = 16'h1234;
      repeat (3) tick();
      check("rst_ready", rdy1, 0);
      check("rst_start", st1, 0);
      check("rst_data", wd1, 0);
      check("rst_count", cnt1, 0);
      check("rst_level", lvl1, 0);
      check("rst_ready7", rdy7, 0);
      v1 = 1'b0;
      rst_n = 1'b1;
      check("rel_ready_before_edge", rdy1, 0);
      tick();
      check("rel_ready_after_edge", rdy1, 1);
      check("rel_level", lvl1, 0);

      // Fill 10..70 back-to-back.
      for (int i = 1; i <= 7; i++) push1(16'(i * 10));
      check("fill_start", st1, 1);
      check("fill_ready", rdy1, 0);
      check("fill_level", lvl1, 7);
      check("fill_data", wd1, {16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10});
      check("fill_k0", wd1[15:0], 16'd10);
      held = wd1;
      v1 = 1'b1; d1 = 16'hBEEF;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i % 5 == 4) begin
            check("hold_start", st1, 1);
            check("hold_data", wd1, held);
            check("hold_level", lvl1, 7);
         end
      end
      v1 = 1'b0;

      // Slide by one.
      dn1 = 1'b1; tick(); dn1 = 1'b0;
      check("slide_count", cnt1, 1);
      check("slide_start_drop", st1, 0);
      check("slide_ready", rdy1, 1);
      check("slide_level", lvl1, 6);
      push1(16'd80);
      check("slide_start", st1, 1);
      check("slide_data", wd1, {16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20});

      // HOP=7 rebuild with negative samples.
      for (int i = 1; i <= 7; i++) push7(16'(i));
      check("h7_start", st7, 1);
      dn7 = 1'b1; tick(); dn7 = 1'b0;
      check("h7_level", lvl7, 0);
      check("h7_count", cnt7, 1);
      check("h7_start_drop", st7, 0);
      for (int i = 1; i <= 6; i++) push7(16'(-i));
      check("h7_not_yet", st7, 0);
      push7(16'hFFF9);
      check("h7_start2", st7, 1);
      check("h7_data", wd7, {16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF});
      check("h7_k0_signed", 128'($signed(wd7[15:0]) == -16'sd1), 1);

      // Flush in WAIT with a coincident done: count must not move.
      fl1 = 1'b1; dn1 = 1'b1; tick(); fl1 = 1'b0; dn1 = 1'b0;
      check("flushw_count", cnt1, 1);
      check("flushw_level", lvl1, 0);
      check("flushw_data", wd1, 0);
      check("flushw_start", st1, 0);
      check("flushw_ready", rdy1, 1);
      for (int i = 1; i <= 4; i++) push1(16'(i));
      check("part_level", lvl1, 4);
      fl1 = 1'b1; v1 = 1'b1; d1 = 16'd99; tick(); fl1 = 1'b0; v1 = 1'b0;
      check("flushf_level", lvl1, 0);
      check("flushf_data", wd1, 0);
      for (int i = 11; i <= 16; i++) push1(16'(i));
      check("refill_not_yet", st1, 0);
      check("refill_level6", lvl1, 6);
      push1(16'd17);
      check("refill_start", st1, 1);
      check("refill_data", wd1, {16'd17, 16'd16, 16'd15, 16'd14, 16'd13, 16'd12, 16'd11});

      // Counter wrap.
      force u_h1.cnt_q = 16'hFFFF;
      #1;
      release u_h1.cnt_q;
      check("wrap_preload", cnt1, 16'hFFFF);
      tick();
      dn1 = 1'b1; tick(); dn1 = 1'b0;
      check("wrap_count", cnt1, 0);
      check("wrap_level", lvl1, 6);

      // Random valid gaps and done timing, scored against a shift-register model.
      for (int k = 0; k < 7; k++) mwin[k] = 16'(11 + k);
      mfill = 3'd6; mcnt = 16'd0; mwait = 1'b0;
      for (int c = 0; c < 400; c++) begin
         v1  = 1'($urandom_range(0, 1));
         d1  = 16'($urandom);
         dn1 = ($urandom_range(0, 3) == 0);
         pre_v = v1; pre_d = dn1; pre_data = d1;
         tick();
         if (!mwait) begin
            if (pre_v) begin
               for (int k = 0; k < 6; k++) mwin[k] = mwin[k+1];
               mwin[6] = pre_data;
               mfill = mfill + 3'd1;
               if (mfill == 3'd7) begin
                  mwait = 1'b1;
                  check("rnd_win_data", wd1, pack(mwin));
                  check("rnd_win_count", cnt1, mcnt);
               end
            end
         end else if (pre_d) begin
            mcnt = mcnt + 16'd1;
            mfill = 3'd6;
            mwait = 1'b0;
         end
         check("rnd_ready", rdy1, !mwait);
         check("rnd_start", st1, mwait);
         check("rnd_level", lvl1, mfill);
      end
      v1 = 1'b0; dn1 = 1'b0;

      // Asynchronous reset while the HOP=7 loader holds a window.
      check("arst_pre_start7", st7, 1);
      rst_n = 1'b0;
      #2;
      check("arst_start7", st7, 0);
      check("arst_data7", wd7, 0);
      check("arst_count7", cnt7, 0);
      check("arst_level7", lvl7, 0);
      check("arst_ready7", rdy7, 0);
      check("arst_count1", cnt1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
